// File: rtl/input_skew_buffer_pkg.sv
// Shared constants and types for the input skew buffer.
// Tile geometry defaults follow the same macros used by output_buffer.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package input_skew_buffer_pkg;

    localparam int DEF_ARRAY_SIZE = `ARRAY_SIZE;
    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

endpackage

// File: rtl/input_skew_lane.sv
// Per-lane diagonal element select: lane LANE at beat t gets row[t-LANE].
// Ports: t (beat index), row (tile row LANE), elem (selected element or 0).
import input_skew_buffer_pkg::*;

module input_skew_lane #(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANE       = 0,
    parameter int TW         = 3
) (
    input  logic [TW-1:0]                    t,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row,
    output logic [DATA_WIDTH-1:0]            elem
);

    always_comb begin
        elem = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            if (int'(t) == LANE + c)
                elem = row[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/input_skew_buffer.sv
// Holds one operand tile and streams it into the array in skewed order.
// Ports: clk/rst; load_en/load_clear/in_row load the tile row by row;
// start/reuse/stall control the feed; out_vec/out_valid carry beats;
// full/busy/done report tile and feed status.
import input_skew_buffer_pkg::*;

module input_skew_buffer #(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_en,
    input  logic                             load_clear,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_row,
    input  logic                             start,
    input  logic                             reuse,
    input  logic                             stall,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_vec,
    output logic                             out_valid,
    output logic                             full,
    output logic                             busy,
    output logic                             done
);

    localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
    localparam int AW    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int PW    = $clog2(ARRAY_SIZE + 1);
    // t runs one past the last beat; that extra step is the completion cycle.
    localparam int TW    = $clog2(2 * ARRAY_SIZE);

    state_t                          state;
    logic [ARRAY_SIZE-1:0][ROW_W-1:0] tile;
    logic [PW-1:0]                   wr_ptr;
    logic [TW-1:0]                   t;
    logic                            reuse_q;
    logic [ROW_W-1:0]                skew;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        input_skew_lane #(
            .ARRAY_SIZE (ARRAY_SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .LANE       (i),
            .TW         (TW)
        ) u_lane (
            .t    (t),
            .row  (tile[i]),
            .elem (skew[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // t is always 0 in IDLE, so the accepting edge registers beat 0
    // directly and the first valid beat follows start by one cycle.
    always_ff @(posedge clk) begin
        if (rst || load_clear) begin
            state     <= IDLE;
            tile      <= '0;
            wr_ptr    <= '0;
            full      <= 1'b0;
            t         <= '0;
            reuse_q   <= 1'b0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_vec   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en && !full) begin
                        tile[wr_ptr[AW-1:0]] <= in_row;
                        wr_ptr <= wr_ptr + 1'b1;
                        full   <= (wr_ptr == PW'(ARRAY_SIZE - 1));
                    end else if (start && full) begin
                        state     <= FEED;
                        busy      <= 1'b1;
                        reuse_q   <= reuse;
                        out_vec   <= skew;
                        out_valid <= 1'b1;
                        t         <= TW'(1);
                    end
                end
                FEED: begin
                    if (t == TW'(2 * ARRAY_SIZE - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        t     <= '0;
                        if (!reuse_q) begin
                            full   <= 1'b0;
                            wr_ptr <= '0;
                        end
                    end else if (!stall) begin
                        out_vec   <= skew;
                        out_valid <= 1'b1;
                        t         <= t + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer with hand-computed beat table.
module tb_input_skew_buffer;

    localparam int N = 4;
    localparam int D = 32;
    localparam int W = N * D;

    logic         clk = 1'b0;
    logic         rst, load_en, load_clear, start, reuse, stall;
    logic [W-1:0] in_row, out_vec;
    logic         out_valid, full, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] beat_tab [7];

    always #5 clk = ~clk;

    input_skew_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_clear (load_clear),
        .in_row     (in_row),
        .start      (start),
        .reuse      (reuse),
        .stall      (stall),
        .out_vec    (out_vec),
        .out_valid  (out_valid),
        .full       (full),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] row_val(input int r);
        logic [W-1:0] v;
        for (int c = 0; c < N; c++) v[c*D +: D] = D'(4 * r + c + 1);
        return v;
    endfunction

    task automatic load_rows(input int first, input int n);
        for (int r = first; r < first + n; r++) begin
            in_row  = row_val(r);
            load_en = 1'b1;
            tick();
        end
        load_en = 1'b0;
        in_row  = '0;
    endtask

    task automatic start_feed(input logic r);
        start = 1'b1;
        reuse = r;
        tick();
        start = 1'b0;
        reuse = 1'b0;
    endtask

    // Expects beat 0 visible on entry; leaves the done cycle visible.
    task automatic run_beats(input string tag, input logic full_exp);
        for (int b = 0; b < 7; b++) begin
            check($sformatf("%s v%0d", tag, b), W'(out_valid), W'(1));
            check($sformatf("%s b%0d", tag, b), out_vec, beat_tab[b]);
            check($sformatf("%s f%0d", tag, b), W'(full), W'(full_exp));
            tick();
        end
    endtask

    task automatic check_done(input string tag, input logic full_exp);
        check({tag, " done"}, W'(done), W'(1));
        check({tag, " oval"}, W'(out_valid), W'(0));
        check({tag, " ovec"}, out_vec, '0);
        check({tag, " busy"}, W'(busy), W'(0));
        check({tag, " full"}, W'(full), W'(full_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

    initial begin
        beat_tab[0] = 128'h00000000_00000000_00000000_00000001;
        beat_tab[1] = 128'h00000000_00000000_00000005_00000002;
        beat_tab[2] = 128'h00000000_00000009_00000006_00000003;
        beat_tab[3] = 128'h0000000D_0000000A_00000007_00000004;
        beat_tab[4] = 128'h0000000E_0000000B_00000008_00000000;
        beat_tab[5] = 128'h0000000F_0000000C_00000000_00000000;
        beat_tab[6] = 128'h00000010_00000000_00000000_00000000;

        rst = 1'b1; load_en = 1'b0; load_clear = 1'b0;
        start = 1'b0; reuse = 1'b0; stall = 1'b0; in_row = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst ovec", out_vec, '0);
        check("rst oval", W'(out_valid), W'(0));
        check("rst full", W'(full), W'(0));
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));

        // 1: basic feed, no reuse
        load_rows(0, 4);
        check("s1 full", W'(full), W'(1));
        start_feed(1'b0);
        check("s1 busy", W'(busy), W'(1));
        run_beats("s1", 1'b1);
        check_done("s1", 1'b0);
        tick();
        check("s1 done1", W'(done), W'(0));

        // 2: reuse with back-to-back replay from the done cycle
        load_rows(0, 4);
        start_feed(1'b1);
        run_beats("s2a", 1'b1);
        check_done("s2a", 1'b1);
        start_feed(1'b1);
        run_beats("s2b", 1'b1);
        check_done("s2b", 1'b1);

        // 3: two-cycle stall at beat 2, tile still held from reuse
        start_feed(1'b1);
        check("s3 b0", out_vec, beat_tab[0]);
        tick();
        check("s3 b1", out_vec, beat_tab[1]);
        stall = 1'b1;
        tick();
        check("s3 st0 v", W'(out_valid), W'(0));
        check("s3 st0 d", out_vec, '0);
        check("s3 st0 busy", W'(busy), W'(1));
        tick();
        check("s3 st1 v", W'(out_valid), W'(0));
        check("s3 st1 d", out_vec, '0);
        stall = 1'b0;
        tick();
        for (int b = 2; b < 7; b++) begin
            check($sformatf("s3 v%0d", b), W'(out_valid), W'(1));
            check($sformatf("s3 b%0d", b), out_vec, beat_tab[b]);
            tick();
        end
        check_done("s3", 1'b1);

        // 4: load_clear at beat 4
        start_feed(1'b0);
        tick(); tick(); tick();
        check("s4 b3", out_vec, beat_tab[3]);
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
        check("s4 oval", W'(out_valid), W'(0));
        check("s4 ovec", out_vec, '0);
        check("s4 full", W'(full), W'(0));
        check("s4 done", W'(done), W'(0));
        check("s4 busy", W'(busy), W'(0));
        tick();
        check("s4 done1", W'(done), W'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4 st oval", W'(out_valid), W'(0));
        check("s4 st busy", W'(busy), W'(0));

        // 5: start with 3 rows ignored; 5th load ignored
        load_rows(0, 3);
        check("s5 full3", W'(full), W'(0));
        start_feed(1'b0);
        tick();
        check("s5 oval", W'(out_valid), W'(0));
        check("s5 busy", W'(busy), W'(0));
        load_rows(3, 1);
        check("s5 full4", W'(full), W'(1));
        in_row  = '1;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        in_row  = '0;
        start_feed(1'b0);
        run_beats("s5", 1'b1);
        check_done("s5", 1'b0);

        // 6: rst mid-feed, then a fresh run
        load_rows(0, 4);
        start_feed(1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6 ovec", out_vec, '0);
        check("s6 oval", W'(out_valid), W'(0));
        check("s6 full", W'(full), W'(0));
        check("s6 busy", W'(busy), W'(0));
        check("s6 done", W'(done), W'(0));
        check("s6 wptr", W'(dut.wr_ptr), '0);
        load_rows(0, 4);
        start_feed(1'b0);
        run_beats("s6", 1'b1);
        check_done("s6", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/input_skew_buffer.md
Name: input_skew_buffer

Overview:
Transmit-side counterpart of output_buffer. It stores one ARRAY_SIZE x ARRAY_SIZE operand tile, loaded one row per cycle, then streams it into the systolic array's edge lanes in diagonal (skewed) order over 2*ARRAY_SIZE-1 beats. Lane packing matches output_buffer's in_res: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH], and lane 0 is the LSBs. An optional reuse mode keeps the tile so it can be replayed across the multiple accumulation passes that output_buffer performs.

Parameters:
ARRAY_SIZE, `ARRAY_SIZE (4), number of array lanes and the tile dimension.
DATA_WIDTH, `DATA_WIDTH (32), width of each element in bits.

Ports:
clk  in  1  clock; every register updates on the rising edge.
rst  in  1  synchronous, active-high reset.
load_en  in  1  write in_row into tile row wr_ptr.
load_clear  in  1  clear the tile, the row pointer and any feed in progress.
in_row  in  ARRAY_SIZE*DATA_WIDTH  one tile row; lane c carries A[row][c].
start  in  1  request a feed of the full tile.
reuse  in  1  sampled with an accepted start; 1 keeps the tile after the feed.
stall  in  1  freeze the feed for this cycle.
out_vec  out  ARRAY_SIZE*DATA_WIDTH  skewed vector to the array, registered.
out_valid  out  1  out_vec holds a feed beat.
full  out  1  all ARRAY_SIZE rows are loaded.
busy  out  1  state is FEED.
done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset: out_vec=0, out_valid=0, full=0, busy=0, done=0, tile storage=0, wr_ptr=0, beat counter t=0, state=IDLE.
- States:
  - IDLE: accepts loads and start.
  - FEED: streams beats.
  - The transition FEED->IDLE raises done for one cycle.
- Load:
  - In IDLE with load_en=1 and full=0, row wr_ptr <= in_row and wr_ptr increments.
  - When wr_ptr reaches ARRAY_SIZE, full=1 on the following cycle.
  - load_en is ignored while full=1 or while in FEED; nothing is written and the pointer is unchanged.
- Start:
  - Accepted only in IDLE with full=1; t <= 0 and state <= FEED.
  - The first out_valid appears on the cycle after acceptance, i.e. 1-cycle latency.
  - start with full=0 is ignored. There is no queuing.
- Skew rule: at beat t (0..2*ARRAY_SIZE-2), lane i = A[i][t-i] when 0 <= t-i < ARRAY_SIZE, else 0. Elements are passed through unchanged; there is no arithmetic.
- Beat advance:
  - Each non-stalled FEED cycle registers beat t with out_valid=1, then t increments.
  - On a stall cycle the next out_valid=0, out_vec=0 and t is held.
  - Whenever out_valid=0, out_vec is forced to 0, so the array always sees zeros outside valid beats.
- Completion:
  - After beat 2*ARRAY_SIZE-2 is registered, the next cycle has out_valid=0, done=1, state=IDLE.
  - If reuse was latched as 0: full<=0, wr_ptr<=0, and storage is left stale. Contents do not matter because the row pointer is reset.
  - If reuse was latched as 1: full stays 1 and the tile can be replayed with a new start.
  - Back-to-back replay: start asserted in the done cycle is accepted. The gap between the two feeds is exactly one zero cycle.
- load_clear has the highest priority of all controls, in any state:
  - Storage, wr_ptr and full are cleared and state <= IDLE.
  - The next cycle has out_valid=0 and out_vec=0. done is not raised.
  - load_en and start in the same cycle as load_clear are ignored.
- Simultaneous load_en on the last row and start in the same cycle: the load is accepted and start is ignored, because full is not yet 1.
- rst has the same effect as load_clear, including mid-feed.
- busy = (state==FEED). It is registered and aligned with state.

Decomposition:
- ARRAY_SIZE and DATA_WIDTH come from the shared config.v, the same `define`s used by output_buffer. The state encodings IDLE=0 and FEED=1 are local parameters.
- One natural sub-module, input_skew_lane:
  - Combinational per-lane element select from (lane index i, t, tile row i).
  - Returns 0 when t-i is out of range.
  - Instantiated ARRAY_SIZE times in a generate loop.
- The top level holds storage, the FSM, counters and output registers.

Test Plan:
1. Load rows A[r][c]=4r+c+1; row 0 in_row=128'h00000004_00000003_00000002_00000001; then start:
   - beat0 out_vec=128'h00000000_00000000_00000000_00000001.
   - beat1 =128'h00000000_00000000_00000005_00000002.
   - beat3 =128'h0000000D_0000000A_00000007_00000004.
   - beat6 =128'h00000010_00000000_00000000_00000000.
   - exactly 7 valid beats, then done=1 for one cycle and full=0.
2. Same tile with reuse=1, start asserted in the done cycle: the identical 7-beat sequence repeats after one zero cycle; full stays 1 throughout.
3. stall held for 2 cycles at beat 2: two cycles with out_valid=0 and out_vec=0, then beat2 (=128'h00000000_00000009_00000006_00000003) resumes; total valid beats still 7.
4. load_clear at beat 4: the next cycle has out_valid=0, out_vec=0, full=0 and no done pulse; a following start is ignored.
5. start after only 3 rows loaded: ignored, out_valid stays 0. A 5th load_en after full: storage unchanged (beat0 still shows lane0 = row-0 value 1).
6. rst asserted mid-feed: the next cycle has all outputs 0 and wr_ptr=0; a fresh 4-row load plus start reproduces scenario 1 exactly.
